// File: rtl/regbank_write_sched.sv
// Round-robin write-port scheduler for the register bank plus INIT zeroing.
// Optional R0_PROTECT_EN: register 0 is never enabled (hard-wired zero).
module regbank_write_sched #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  input  logic               hold,
  input  logic               init,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic               busy,
  output logic               init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef R0_PROTECT_EN
  localparam logic [NREG-1:0] EN_MASK = ~{{(NREG-1){1'b0}}, 1'b1};
`else
  localparam logic [NREG-1:0] EN_MASK = '1;
`endif

  typedef enum logic {
    IDLE,
    INIT
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_q;
  logic [AW-1:0]   cnt_q;
  logic [NREG-1:0] en_q;
  logic [DW-1:0]   d_q;
  logic            busy_q;
  logic            done_q;

  logic            gvld;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   rr_nxt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Out-of-range addresses decode to no enable (write dropped).
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    if (int'(a) < NREG) v[a] = 1'b1;
    return v;
  endfunction

  // Round-robin pick starting at rr_q; idle, unstalled, out of reset only.
  always_comb begin
    int idx;
    idx  = 0;
    gvld = 1'b0;
    gidx = '0;
    gnt  = '0;
    if (clr && state_q == IDLE && !hold && !init) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_q) + k) % NREQ;
        if (!gvld && req[idx]) begin
          gvld = 1'b1;
          gidx = PW'(idx);
        end
      end
      if (gvld) gnt[gidx] = 1'b1;
    end
  end

  // Selected requester's address/data and the pointer that follows it.
  always_comb begin
    sel_addr = addr[int'(gidx)*AW +: AW];
    sel_data = wdata[int'(gidx)*DW +: DW];
    rr_nxt   = PW'((int'(gidx) + 1) % NREQ);
  end

  // Control FSM with registered bank-side outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (init) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            en_q    <= '0;
          end else if (gvld) begin
            en_q <= onehot(sel_addr) & EN_MASK;
            d_q  <= sel_data;
            rr_q <= rr_nxt;
          end else begin
            en_q <= '0;
          end
        end
        INIT: begin
          if (hold) begin
            en_q <= '0;
          end else begin
            en_q  <= onehot(cnt_q) & EN_MASK;
            d_q   <= '0;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_en    = en_q;
  assign reg_d     = d_q;
  assign busy      = busy_q;
  assign init_done = done_q;

endmodule
